// File: rtl/data_sink_fifo_if.sv
// rtl/data_sink_fifo_if.sv - sample-in / head-out handshake and status bundle for data_sink_fifo
interface data_sink_fifo_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] drop_cnt;
  logic             overflow;
  logic             clr;

  // Producer/consumer side: drives samples, ready and clear, observes the rest
  modport master (
    output in_valid, in_data, out_ready, clr,
    input  out_valid, out_data, count, full, empty, drop_cnt, overflow
  );

  // FIFO side
  modport slave (
    input  in_valid, in_data, out_ready, clr,
    output out_valid, out_data, count, full, empty, drop_cnt, overflow
  );
endinterface

// File: rtl/data_sink_fifo.sv
// rtl/data_sink_fifo.sv - FWFT sample FIFO with drop counting and sticky overflow flag
module data_sink_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  data_sink_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
  localparam logic [CNT_W-1:0] DROP_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [CNT_W-1:0] dcnt;
  logic             ovf;

  logic is_full;
  logic is_empty;
  logic pop;
  logic push;
  logic drop;

  // Status comes from the occupancy register only; pointers are never compared
  assign is_full  = (cnt == CNT_FULL);
  assign is_empty = (cnt == '0);

  // A full FIFO still accepts a sample when the head leaves in the same cycle
  assign pop  = !is_empty && bus.out_ready;
  assign push = bus.in_valid && (!is_full || pop);
  assign drop = bus.in_valid && is_full && !pop;

  // Sample storage; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Loss statistics: a drop in the same cycle as clr restarts the count at one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt <= '0;
      ovf  <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (bus.clr) begin
        dcnt <= CNT_W'(1);
      end else if (dcnt != DROP_MAX) begin
        dcnt <= dcnt + CNT_W'(1);
      end
    end else if (bus.clr) begin
      dcnt <= '0;
      ovf  <= 1'b0;
    end
  end

  assign bus.out_valid = !is_empty;
  assign bus.out_data  = is_empty ? '0 : mem[rd_ptr];
  assign bus.count     = cnt;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.drop_cnt  = dcnt;
  assign bus.overflow  = ovf;
endmodule

// File: tb/tb_data_sink_fifo.sv
// tb/tb_data_sink_fifo.sv - scoreboard bench for data_sink_fifo
module tb_data_sink_fifo;
  logic clk;
  logic rst_n;

  data_sink_fifo_if #(.WIDTH(4), .DEPTH(8), .CNT_W(8)) b  ();
  data_sink_fifo_if #(.WIDTH(4), .DEPTH(8), .CNT_W(2)) b2 ();

  data_sink_fifo #(.WIDTH(4), .DEPTH(8), .CNT_W(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(b));
  data_sink_fifo #(.WIDTH(4), .DEPTH(8), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] mq [$];
  int m_drop = 0;
  int m_ovf  = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle on the main DUT: drive at negedge, score the head on pop, check status after the edge
  task automatic step(input logic iv, input logic [3:0] d, input logic ordy, input logic c);
    logic pop, full, push, drop;
    logic [3:0] exp;
    @(negedge clk);
    b.in_valid = iv; b.in_data = d; b.out_ready = ordy; b.clr = c;
    #1;
    pop  = (mq.size() != 0) && ordy;
    full = (mq.size() == 8);
    push = iv && (!full || pop);
    drop = iv && full && !pop;
    expect_eq("out_valid", 32'(b.out_valid), 32'(mq.size() != 0));
    if (pop) begin
      exp = mq.pop_front();
      expect_eq("out_data", 32'(b.out_data), 32'(exp));
    end
    if (push) mq.push_back(d);
    if (drop) begin
      m_drop = c ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
      m_ovf  = 1;
    end else if (c) begin
      m_drop = 0;
      m_ovf  = 0;
    end
    @(posedge clk);
    #1;
    expect_eq("count",    32'(b.count),    32'(mq.size()));
    expect_eq("drop_cnt", 32'(b.drop_cnt), 32'(m_drop));
    expect_eq("overflow", 32'(b.overflow), 32'(m_ovf));
  endtask

  task automatic step2(input logic iv, input logic [3:0] d, input logic ordy, input logic c);
    @(negedge clk);
    b2.in_valid = iv; b2.in_data = d; b2.out_ready = ordy; b2.clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    b.in_valid = 0;  b.in_data = 0;  b.out_ready = 0;  b.clr = 0;
    b2.in_valid = 0; b2.in_data = 0; b2.out_ready = 0; b2.clr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    #1;
    expect_eq("rst_count",    32'(b.count),     32'(0));
    expect_eq("rst_empty",    32'(b.empty),     32'(1));
    expect_eq("rst_full",     32'(b.full),      32'(0));
    expect_eq("rst_out_data", 32'(b.out_data),  32'(0));
    expect_eq("rst_drop",     32'(b.drop_cnt),  32'(0));
    expect_eq("rst_ovf",      32'(b.overflow),  32'(0));

    // Fill 1..8 then drain in order
    for (int i = 1; i <= 8; i++) step(1, 4'(i), 0, 0);
    expect_eq("fill_full",  32'(b.full),  32'(1));
    expect_eq("fill_count", 32'(b.count), 32'(8));
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    expect_eq("drain_empty", 32'(b.empty), 32'(1));
    expect_eq("drain_data0", 32'(b.out_data), 32'(0));

    // Overflow while full, then simultaneous push/pop at full
    for (int i = 1; i <= 8; i++) step(1, 4'(i), 0, 0);
    step(1, 4'd9, 0, 0);
    step(1, 4'd10, 0, 0);
    expect_eq("ovf_drop", 32'(b.drop_cnt), 32'(2));
    expect_eq("ovf_flag", 32'(b.overflow), 32'(1));
    expect_eq("ovf_head", 32'(b.out_data), 32'(1));
    step(1, 4'd9, 1, 0);
    expect_eq("sim_count", 32'(b.count),    32'(8));
    expect_eq("sim_drop",  32'(b.drop_cnt), 32'(2));
    expect_eq("sim_head",  32'(b.out_data), 32'(2));
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    expect_eq("drain2_empty", 32'(b.empty), 32'(1));
    step(0, 0, 0, 1);
    expect_eq("clr_drop", 32'(b.drop_cnt), 32'(0));

    // Wrap-around with toggling ready
    for (int i = 0; i < 20; i++) begin
      step(1, 4'($urandom_range(0, 15)), (i % 2) == 0, 0);
      expect_eq("count_le8", 32'(b.count <= 8), 32'(1));
    end
    for (int i = 0; i < 10 && mq.size() != 0; i++) step(0, 0, 1, 0);
    expect_eq("wrap_drained", 32'(b.empty), 32'(1));

    // Saturating drop counter on the narrow instance
    for (int i = 1; i <= 8; i++) step2(1, 4'(i), 0, 0);
    for (int i = 0; i < 5; i++) step2(1, 4'hf, 0, 0);
    expect_eq("sat_drop", 32'(b2.drop_cnt), 32'(3));
    expect_eq("sat_ovf",  32'(b2.overflow), 32'(1));
    step2(0, 0, 0, 1);
    expect_eq("clr_sat_drop", 32'(b2.drop_cnt), 32'(0));
    expect_eq("clr_sat_ovf",  32'(b2.overflow), 32'(0));
    expect_eq("clr_count",    32'(b2.count),    32'(8));
    step2(1, 4'h5, 0, 1);
    expect_eq("clrdrop_cnt", 32'(b2.drop_cnt), 32'(1));
    expect_eq("clrdrop_ovf", 32'(b2.overflow), 32'(1));
    step2(0, 0, 0, 0);

    // Asynchronous reset mid-stream with five entries and a nonzero drop count
    for (int i = 1; i <= 8; i++) step(1, 4'(i), 0, 0);
    step(1, 4'd9, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    expect_eq("pre_rst_count", 32'(b.count), 32'(5));
    @(negedge clk);
    b.in_valid = 0; b.out_ready = 0;
    #2 rst_n = 1'b0;
    #1;
    expect_eq("arst_count",    32'(b.count),    32'(0));
    expect_eq("arst_empty",    32'(b.empty),    32'(1));
    expect_eq("arst_out_data", 32'(b.out_data), 32'(0));
    expect_eq("arst_drop",     32'(b.drop_cnt), 32'(0));
    expect_eq("arst_ovf",      32'(b.overflow), 32'(0));
    mq.delete();
    m_drop = 0;
    m_ovf  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 4'd7, 0, 0);
    step(0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
